// File: rtl/dest_track_pkg.sv
// Shared widths, write-type encodings and the stage entry for the destination tracker.
// Write type: bit0 result ready at WB, bit1 at MEM, bit2 at EXE; 000 means no register write.
package dest_track_pkg;

    localparam int REG_W  = 5;
    localparam int TYPE_W = 3;

    localparam logic [TYPE_W-1:0] WT_NONE = 3'b000;
    localparam logic [TYPE_W-1:0] WT_WB   = 3'b001;
    localparam logic [TYPE_W-1:0] WT_MEM  = 3'b010;
    localparam logic [TYPE_W-1:0] WT_EXE  = 3'b100;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  wnum;
        logic [TYPE_W-1:0] wtype;
    } stage_entry_t;

    // Hazard-facing view of an entry: an empty stage never claims a write.
    function automatic logic [TYPE_W-1:0] gated_wtype(stage_entry_t e);
        return e.valid ? e.wtype : WT_NONE;
    endfunction

endpackage

// File: rtl/dest_stage.sv
// Purpose: one pipeline stage register holding {valid, wnum, wtype}.
// Latency: one cycle from an accepted upstream entry to this stage's output.
// Backpressure: allowin drops while holding a valid entry that cannot leave; flush empties it.
module dest_stage
    import dest_track_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  stage_entry_t in_entry,
    input  logic         next_allowin,
    input  logic         ready_go,
    input  logic         flush,
    output logic         allowin,
    output stage_entry_t entry
);

    assign allowin = !entry.valid || (ready_go && next_allowin);

    // Flush clears occupancy even while stalled; the stored number/type are kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry <= '0;
        end else if (allowin) begin
            entry <= '{valid: in_entry.valid && !flush,
                       wnum:  in_entry.wnum,
                       wtype: in_entry.wtype};
        end else begin
            entry.valid <= entry.valid && !flush;
        end
    end

endmodule

// File: rtl/dest_track.sv
// Purpose: carry issued destination register/write type through EXE, MEM, WB for hazard checks.
// Latency: accepted at edge N -> EXE N+1, MEM N+2, WB N+3, register written at edge N+4.
// Backpressure: exe/mem ready_go stalls propagate to id_allowin; flush blocks issue and clears EXE/MEM.
module dest_track
    import dest_track_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_wnum,
    input  logic [TYPE_W-1:0] id_wtype,
    output logic              id_allowin,
    input  logic              exe_ready_go,
    input  logic              mem_ready_go,
    input  logic              flush,
    output logic [TYPE_W-1:0] exe_write_type,
    output logic [REG_W-1:0]  exe_wnum,
    output logic [TYPE_W-1:0] mem_write_type,
    output logic [REG_W-1:0]  mem_wnum,
    output logic [TYPE_W-1:0] wb_write_type,
    output logic [REG_W-1:0]  wb_wnum,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr
);

    stage_entry_t exe_in, mem_in, wb_in;
    stage_entry_t exe_q, mem_q, wb_q;
    logic         exe_allowin, mem_allowin, wb_allowin;

    // $0 is never a real write, so it must never look like a hazard.
    assign exe_in = '{valid: id_valid,
                      wnum:  id_wnum,
                      wtype: (id_wnum == '0) ? WT_NONE : id_wtype};
    assign mem_in = '{valid: exe_q.valid && exe_ready_go, wnum: exe_q.wnum, wtype: exe_q.wtype};
    assign wb_in  = '{valid: mem_q.valid && mem_ready_go, wnum: mem_q.wnum, wtype: mem_q.wtype};

    dest_stage u_exe (
        .clk          (clk),
        .rst          (rst),
        .in_entry     (exe_in),
        .next_allowin (mem_allowin),
        .ready_go     (exe_ready_go),
        .flush        (flush),
        .allowin      (exe_allowin),
        .entry        (exe_q)
    );

    dest_stage u_mem (
        .clk          (clk),
        .rst          (rst),
        .in_entry     (mem_in),
        .next_allowin (wb_allowin),
        .ready_go     (mem_ready_go),
        .flush        (flush),
        .allowin      (mem_allowin),
        .entry        (mem_q)
    );

    // WB retires in a single cycle, so it is always ready and always open.
    dest_stage u_wb (
        .clk          (clk),
        .rst          (rst),
        .in_entry     (wb_in),
        .next_allowin (1'b1),
        .ready_go     (1'b1),
        .flush        (flush),
        .allowin      (wb_allowin),
        .entry        (wb_q)
    );

    assign id_allowin     = exe_allowin && !flush;

    assign exe_write_type = gated_wtype(exe_q);
    assign mem_write_type = gated_wtype(mem_q);
    assign wb_write_type  = gated_wtype(wb_q);
    assign exe_wnum       = exe_q.wnum;
    assign mem_wnum       = mem_q.wnum;
    assign wb_wnum        = wb_q.wnum;

    assign rf_we          = wb_q.valid && (wb_q.wtype != WT_NONE);
    assign rf_waddr       = wb_q.wnum;

endmodule

// File: tb/tb_dest_track.sv
// Bench for dest_track: reference pipeline model plus a write scoreboard drained by a monitor.
module tb_dest_track;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_wnum = '0;
    logic [2:0] id_wtype = '0;
    logic       id_allowin;
    logic       exe_ready_go = 1'b1;
    logic       mem_ready_go = 1'b1;
    logic       flush = 1'b0;
    logic [2:0] exe_write_type, mem_write_type, wb_write_type;
    logic [4:0] exe_wnum, mem_wnum, wb_wnum;
    logic       rf_we;
    logic [4:0] rf_waddr;

    int checks = 0;
    int failures = 0;

    // Expected register-file writes, oldest first.
    int exp_writes[$];

    // Reference pipeline: index 0 = EXE, 1 = MEM, 2 = WB.
    bit m_v[3];
    int m_n[3];
    int m_t[3];

    dest_track dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_wnum        (id_wnum),
        .id_wtype       (id_wtype),
        .id_allowin     (id_allowin),
        .exe_ready_go   (exe_ready_go),
        .mem_ready_go   (mem_ready_go),
        .flush          (flush),
        .exe_write_type (exe_write_type),
        .exe_wnum       (exe_wnum),
        .mem_write_type (mem_write_type),
        .mem_wnum       (mem_wnum),
        .wb_write_type  (wb_write_type),
        .wb_wnum        (wb_wnum),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic bit mem_can_take();
        return !m_v[1] || mem_ready_go;
    endfunction

    function automatic bit exe_can_take();
        return !m_v[0] || (exe_ready_go && mem_can_take());
    endfunction

    // One clock: apply inputs, compare at negedge, advance the model at posedge.
    task automatic step(input bit v, input int wn, input int wt,
                        input bit eg, input bit mg, input bit fl, input bit r);
        int drop;
        bit accept;
        id_valid = v; id_wnum = 5'(wn); id_wtype = 3'(wt);
        exe_ready_go = eg; mem_ready_go = mg; flush = fl; rst = r;
        @(negedge clk);
        accept = v && exe_can_take() && !fl;
        chk("id_allowin", int'(id_allowin), int'(exe_can_take() && !fl));
        chk("exe_write_type", int'(exe_write_type), m_v[0] ? m_t[0] : 0);
        chk("mem_write_type", int'(mem_write_type), m_v[1] ? m_t[1] : 0);
        chk("wb_write_type", int'(wb_write_type), m_v[2] ? m_t[2] : 0);
        chk("exe_wnum", int'(exe_wnum), m_n[0]);
        chk("mem_wnum", int'(mem_wnum), m_n[1]);
        chk("wb_wnum", int'(wb_wnum), m_n[2]);
        chk("rf_we", int'(rf_we), int'(m_v[2] && m_t[2] != 0));
        if (!r && accept && wn != 0 && wt != 0)
            exp_writes.push_back(wn);
        if (!r && fl) begin
            drop = 0;
            for (int s = 0; s < 2; s++)
                if (m_v[s] && m_t[s] != 0) drop++;
            for (int k = 0; k < drop; k++)
                if (exp_writes.size() > 0) void'(exp_writes.pop_back());
        end
        @(posedge clk);
        if (r) begin
            for (int s = 0; s < 3; s++) begin m_v[s] = 0; m_n[s] = 0; m_t[s] = 0; end
            exp_writes.delete();
        end else begin
            bit take_exe, take_mem;
            take_exe = exe_can_take();
            take_mem = mem_can_take();
            m_v[2] = m_v[1] && mg && !fl;
            m_n[2] = m_n[1];
            m_t[2] = m_t[1];
            if (take_mem) begin
                m_v[1] = m_v[0] && eg && !fl;
                m_n[1] = m_n[0];
                m_t[1] = m_t[0];
            end else begin
                m_v[1] = m_v[1] && !fl;
            end
            if (take_exe) begin
                m_v[0] = v && !fl;
                m_n[0] = wn;
                m_t[0] = (wn == 0) ? 0 : wt;
            end else begin
                m_v[0] = m_v[0] && !fl;
            end
        end
        #1;
    endtask

    // Monitor: every register-file write must be the oldest outstanding expected write.
    initial begin
        forever begin
            @(negedge clk);
            if (rf_we === 1'b1) begin
                if (exp_writes.size() == 0) begin
                    chk("rf_we_unexpected", int'(rf_waddr), -1);
                end else begin
                    chk("rf_waddr", int'(rf_waddr), exp_writes.pop_front());
                end
            end
        end
    end

    initial begin
        for (int s = 0; s < 3; s++) begin m_v[s] = 0; m_n[s] = 0; m_t[s] = 0; end
        step(0, 0, 0, 1, 1, 0, 1);
        step(0, 0, 0, 1, 1, 0, 0);

        // Back-to-back stream 5/6/7.
        step(1, 5, 1, 1, 1, 0, 0);
        chk("stream_exe5", int'(exe_wnum), 5);
        step(1, 6, 1, 1, 1, 0, 0);
        chk("stream_mem5", int'(mem_wnum), 5);
        step(1, 7, 1, 1, 1, 0, 0);
        chk("stream_wb5", int'(wb_wnum), 5);
        chk("stream_we5", int'(rf_we), 1);
        step(0, 0, 0, 1, 1, 0, 0);
        chk("stream_waddr6", int'(rf_waddr), 6);
        step(0, 0, 0, 1, 1, 0, 0);
        chk("stream_waddr7", int'(rf_waddr), 7);

        // $0 destination never claims a write.
        step(1, 0, 4, 1, 1, 0, 0);
        chk("zero_exe_type", int'(exe_write_type), 0);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        chk("zero_rf_we", int'(rf_we), 0);

        // EXE stall with 9 in EXE.
        step(1, 9, 4, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 20, 1, 0, 1, 0, 0);
            chk("exe_stall_type", int'(exe_write_type), 4);
        end
        chk("exe_stall_bubble", int'(mem_write_type), 0);
        step(0, 0, 0, 1, 1, 0, 0);
        chk("exe_stall_mem9", int'(mem_wnum), 9);
        chk("exe_stall_mem9_type", int'(mem_write_type), 4);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);

        // MEM stall with 3 in MEM and 4 in EXE.
        step(1, 3, 2, 1, 1, 0, 0);
        step(1, 4, 1, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(1, 8, 1, 1, 0, 0, 0);
            chk("mem_stall_mem3", int'(mem_wnum), 3);
            chk("mem_stall_exe4", int'(exe_wnum), 4);
            chk("mem_stall_wb_bubble", int'(wb_write_type), 0);
        end
        step(0, 0, 0, 1, 1, 0, 0);
        chk("mem_resume_wb3", int'(wb_wnum), 3);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);

        // Flush with 10/11/12 in EXE/MEM/WB.
        step(1, 12, 1, 1, 1, 0, 0);
        step(1, 11, 1, 1, 1, 0, 0);
        step(1, 10, 1, 1, 1, 0, 0);
        chk("flush_we12", int'(rf_we), 1);
        chk("flush_waddr12", int'(rf_waddr), 12);
        step(1, 13, 1, 1, 1, 1, 0);
        chk("flush_exe_clear", int'(exe_write_type), 0);
        chk("flush_mem_clear", int'(mem_write_type), 0);
        chk("flush_wb_clear", int'(wb_write_type), 0);
        step(0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);

        // Reset during a MEM stall.
        step(1, 14, 1, 1, 1, 0, 0);
        step(1, 15, 2, 1, 1, 0, 0);
        step(1, 16, 1, 1, 0, 0, 1);
        chk("rst_exe_type", int'(exe_write_type), 0);
        chk("rst_mem_type", int'(mem_write_type), 0);
        chk("rst_wb_type", int'(wb_write_type), 0);
        chk("rst_rf_we", int'(rf_we), 0);
        step(0, 0, 0, 1, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int wn;
            wn = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 31));
            step(bit'($urandom_range(0, 9) < 7), wn, int'($urandom_range(0, 7)),
                 bit'($urandom_range(0, 9) < 8), bit'($urandom_range(0, 9) < 8),
                 bit'($urandom_range(0, 19) == 0), bit'($urandom_range(0, 199) == 0));
        end

        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1, 0, 0);
        chk("drain_outstanding", exp_writes.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dest_track.md
Name: dest_track

Overview:
- Producer side of the ID-stage hazard interface. Carries each issued instruction's destination register number and 3-bit write type through EXE, MEM and WB stage registers.
- Uses valid/allowin handshakes with per-stage ready_go, plus a flush.
- Drives the exe/mem/wb write_type and wnum signals that the ID readiness checker compares against RR1/RR2.
- Also drives the WB register-file write-enable and address.

Parameters:
- REG_W, 5, register-number width.
- TYPE_W, 3, write-type width. Encoding: bit0 = result ready at WB, bit1 = ready at MEM, bit2 = ready at EXE; 000 = no register write.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds an instruction ready to issue.
- id_wnum  in  REG_W  destination register of the ID instruction.
- id_wtype  in  TYPE_W  write type of the ID instruction.
- id_allowin  out  1  EXE accepts the ID instruction this cycle.
- exe_ready_go  in  1  EXE result complete (multi-cycle mul/div).
- mem_ready_go  in  1  MEM complete (data_ok returned).
- flush  in  1  exception/eret flush of the younger stages.
- exe_write_type  out  TYPE_W  EXE write type, gated by exe_valid.
- exe_wnum  out  REG_W  EXE destination register.
- mem_write_type  out  TYPE_W  MEM write type, gated by mem_valid.
- mem_wnum  out  REG_W  MEM destination register.
- wb_write_type  out  TYPE_W  WB write type, gated by wb_valid.
- wb_wnum  out  REG_W  WB destination register.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_W  register-file write address.

Behaviour:
- Reset: all stage valids = 0, stored wnum = 0, stored wtype = 000.
  - Every write_type output = 000 and every wnum = 0; rf_we = 0.
  - id_allowin = 1 in the first cycle after reset (unless flush).
- Handshake (combinational):
  - wb_allowin = 1 (WB completes in one cycle).
  - mem_allowin = !mem_valid || (mem_ready_go && wb_allowin).
  - exe_allowin = !exe_valid || (exe_ready_go && mem_allowin).
  - id_allowin = exe_allowin && !flush.
- Stage advance at each posedge clk:
  - EXE: if exe_allowin, then exe_valid <= id_valid && !flush, and load wnum/wtype.
  - MEM: if mem_allowin, then mem_valid <= exe_valid && exe_ready_go && !flush, and copy from EXE.
  - WB: wb_valid <= mem_valid && mem_ready_go && !flush, and copy from MEM.
  - A stage that is not allowed in holds its contents.
- Latency: an instruction accepted at edge N occupies EXE in cycle N+1. With all ready_go high it is in MEM at N+2, in WB at N+3, and the register is written at edge N+4.
- $0 rule: if id_wnum == 0, the stored wtype is forced to 000. $0 never causes a stall and is never written.
- Output gating: X_write_type = X_valid ? stored_wtype : 000. wnum outputs always show the stored value.
- rf_we = wb_valid && (wb wtype != 000); rf_waddr = wb wnum.
- Flush:
  - In the flush cycle, EXE and MEM are cleared at the next edge and ID is not accepted.
  - An instruction currently in MEM does not advance to WB.
  - An instruction already in WB still commits.
  - flush wins over id_valid and over every ready_go.
- Stalls and bubbles:
  - exe_ready_go = 0 holds EXE and stops accepts from ID. MEM drains and then goes invalid (a bubble).
  - mem_ready_go = 0 holds both MEM and EXE; EXE then keeps its write_type visible to the hazard checker.
- Simultaneous accept and drain: EXE may load a new entry in the same cycle that its old entry moves to MEM; nothing is lost or duplicated.
- Reset mid-operation: the state returns to the reset values at the next edge, regardless of stalls or flush.

Decomposition:
- Shared package holds:
  - REG_W, TYPE_W.
  - WT_NONE = 3'b000, WT_WB = 3'b001, WT_MEM = 3'b010, WT_EXE = 3'b100.
  - A typedef for the stage entry {valid, wnum, wtype}.
- One natural sub-module: dest_stage, a generic stage register with allowin, ready_go, flush and a load/hold mux. It is instantiated three times, with WB's ready_go tied to 1.

Test Plan:
- Stream: id_valid = 1 with wnum 5/6/7 and wtype 001, all ready_go = 1.
  - Required: exe_wnum = 5 at cycle 1, mem_wnum = 5 at cycle 2, wb_wnum = 5 at cycle 3.
  - Required: rf_we = 1, rf_waddr = 5 at cycle 3; then 6 and 7 in consecutive cycles.
- $0 destination: id_wnum = 0, wtype 100.
  - Required: exe_write_type = 000 and, three cycles later, rf_we = 0.
- EXE stall: exe_ready_go = 0 for 3 cycles with wnum 9 in EXE.
  - Required: exe_write_type stays 100 and id_allowin = 0 for those 3 cycles.
  - Required: mem_write_type = 000 while the bubble is present; 9 reaches MEM one cycle after exe_ready_go returns high.
- MEM stall: mem_ready_go = 0 with wnum 3 in MEM and 4 in EXE.
  - Required: both stages hold; wb_write_type = 000 (bubble).
  - Required: id_allowin = 0; the flow resumes in order once mem_ready_go rises.
- Flush: flush = 1 with 10 in EXE, 11 in MEM, 12 in WB, and id_valid = 1.
  - Required: rf_we = 1 to 12 at that cycle; next cycle exe/mem/wb write types are all 000, and 10/11 are never written.
- Reset mid-stall: assert rst while mem_ready_go = 0.
  - Required: next cycle all write types = 000, rf_we = 0, id_allowin = 1.
